// File: rtl/rv32i_trap_ctrl.sv
// ============================================================================
// rv32i_trap_ctrl
// ----------------------------------------------------------------------------
// Machine-mode trap sequencer for a small RV32I core. It arbitrates between
// synchronous exceptions, MRET, and the machine external/timer interrupts.
// It tells the CSR file to enter or leave a trap, and then hands the new fetch
// PC to the front end through a valid/ready redirect handshake.
//
// Sequence: IDLE -> TRAP|MRET (one cycle, trigger + flush) -> REDIR (hold
// until redirect_ready) -> IDLE. Requests are only sampled in IDLE. Requests
// that arrive while the sequencer is busy are not queued. The requester must
// keep them asserted.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   exc_valid/cause/pc/tval  exception request from the pipeline
//   mret_req            MRET request from the pipeline
//   irq_pc, commit_ok   interrupt return PC, interruptible-boundary flag
//   ext_irq             machine external interrupt line
//   mstatus_in, mie_in, mip_in, mtvec_in, mepc_in   current CSR values
//   exception_trigger/cause/pc/value   trap-entry command to the CSR file
//   mret_trigger        trap-return command to the CSR file
//   redirect_valid/pc/ready            fetch redirect handshake
//   stall, flush        pipeline hold and younger-instruction kill
//
// Configuration
//   TRAP_VECTORED_EN    when defined, an interrupt taken with mtvec mode 01
//                       vectors to base + 4*cause. Otherwise every trap
//                       goes to the mtvec base.
// ============================================================================
module rv32i_trap_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic [31:0] irq_pc,
    input  logic        commit_ok,
    input  logic        ext_irq,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mie_in,
    input  logic [31:0] mip_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        exception_trigger,
    output logic [31:0] exception_cause,
    output logic [31:0] exception_pc,
    output logic [31:0] exception_value,
    output logic        mret_trigger,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        stall,
    output logic        flush
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAP  = 2'd1;
    localparam logic [1:0] MRET  = 2'd2;
    localparam logic [1:0] REDIR = 2'd3;

    localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TMR_IRQ = 32'h8000_0007;

    logic [1:0]  state_q,  state_d;
    logic [31:0] cause_q,  cause_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] value_q,  value_d;
    logic [31:0] target_q, target_d;

    logic        ext_eligible;
    logic        tmr_eligible;
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    // Interrupts are only eligible when global MIE is set and the pipeline
    // sits at an interruptible boundary. These terms are consulted only in
    // IDLE. During TRAP the CSR file clears MIE, so the same interrupt
    // cannot be re-taken.
    assign ext_eligible = ext_irq    & mie_in[11] & mstatus_in[3] & commit_ok;
    assign tmr_eligible = mip_in[7]  & mie_in[7]  & mstatus_in[3] & commit_ok;
    assign mtvec_base   = {mtvec_in[31:2], 2'b00};

    // Trap target is computed during TRAP from the latched cause. Bit 31
    // marks an interrupt, and only interrupts may be vectored.
`ifdef TRAP_VECTORED_EN
    assign trap_target = (cause_q[31] && (mtvec_in[1:0] == 2'b01))
                       ? mtvec_base + {26'd0, cause_q[3:0], 2'b00}
                       : mtvec_base;
`else
    assign trap_target = mtvec_base;
`endif

    // Next-state logic. Priority in IDLE is exception > MRET > external
    // interrupt > timer interrupt.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        value_d  = value_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    state_d = TRAP;
                    cause_d = {28'h0, exc_cause};
                    pc_d    = exc_pc;
                    value_d = exc_tval;
                end else if (mret_req) begin
                    state_d = MRET;
                end else if (ext_eligible) begin
                    state_d = TRAP;
                    cause_d = CAUSE_EXT_IRQ;
                    pc_d    = irq_pc;
                    value_d = 32'h0;
                end else if (tmr_eligible) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TMR_IRQ;
                    pc_d    = irq_pc;
                    value_d = 32'h0;
                end
            end
            TRAP: begin
                target_d = trap_target;
                state_d  = REDIR;
            end
            MRET: begin
                target_d = {mepc_in[31:2], 2'b00};
                state_d  = REDIR;
            end
            REDIR: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched trap data. An asynchronous reset drops any
    // in-flight operation, and every output returns to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cause_q  <= 32'h0;
            pc_q     <= 32'h0;
            value_q  <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            value_q  <= value_d;
            target_q <= target_d;
        end
    end

    assign exception_trigger = (state_q == TRAP);
    assign mret_trigger      = (state_q == MRET);
    assign flush             = (state_q == TRAP) || (state_q == MRET);
    assign stall             = (state_q != IDLE);
    assign redirect_valid    = (state_q == REDIR);
    assign redirect_pc       = {target_q[31:2], 2'b00};
    assign exception_cause   = cause_q;
    assign exception_pc      = pc_q;
    assign exception_value   = value_q;

    // CSR bits that this block does not care about.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{mstatus_in[31:4], mstatus_in[2:0],
                               mie_in[31:12], mie_in[10:8], mie_in[6:0],
                               mip_in[31:8], mip_in[6:0],
                               mtvec_in[1:0], mepc_in[1:0]};

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// ============================================================================
// tb_rv32i_trap_ctrl
// ----------------------------------------------------------------------------
// Directed bench for rv32i_trap_ctrl. The stimulus tasks push the expected
// trap/MRET/redirect events into a queue. A negedge monitor pops each event
// as the DUT presents it and compares the event against the queue entry.
// Any DUT event that arrives when none is expected counts as a failure.
// ============================================================================
module tb_rv32i_trap_ctrl;

    localparam logic [1:0] K_TRAP  = 2'd0;
    localparam logic [1:0] K_MRET  = 2'd1;
    localparam logic [1:0] K_REDIR = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        mret_req;
    logic [31:0] irq_pc;
    logic        commit_ok, ext_irq;
    logic [31:0] mstatus_in, mie_in, mip_in, mtvec_in, mepc_in;
    logic        exception_trigger;
    logic [31:0] exception_cause, exception_pc, exception_value;
    logic        mret_trigger;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        stall, flush;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] VEC_EXT_TARGET = 32'h0000_032C;
`else
    localparam logic [31:0] VEC_EXT_TARGET = 32'h0000_0300;
`endif

    rv32i_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_req(mret_req), .irq_pc(irq_pc), .commit_ok(commit_ok), .ext_irq(ext_irq),
        .mstatus_in(mstatus_in), .mie_in(mie_in), .mip_in(mip_in),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in),
        .exception_trigger(exception_trigger), .exception_cause(exception_cause),
        .exception_pc(exception_pc), .exception_value(exception_value),
        .mret_trigger(mret_trigger),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready),
        .stall(stall), .flush(flush)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Watchdog that stops a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: bump the counters and report a mismatch.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [31:0] cause,
                            input logic [31:0] pc, input logic [31:0] value);
        exp_t e;
        e.kind = kind; e.cause = cause; e.pc = pc; e.value = value;
        exp_q.push_back(e);
    endtask

    // Wait until the DUT is back in IDLE. The wait is bounded.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (!stall) break;
        end
        check_output(name, {31'd0, stall}, 32'd0);
    endtask

    // Issue an exception for one cycle, with direct latency checks. The DUT
    // must be in IDLE at posedge+1 when this is called.
    task automatic apply_stimulus_exc(input logic [3:0] cause, input logic [31:0] pc,
                                      input logic [31:0] tval, input logic [31:0] target);
        push_exp(K_TRAP, {28'h0, cause}, pc, tval);
        push_exp(K_REDIR, 32'h0, target, 32'h0);
        exc_valid = 1'b1; exc_cause = cause; exc_pc = pc; exc_tval = tval;
        @(posedge clk); #1;
        exc_valid = 1'b0;
        check_output("trap_latency", {31'd0, exception_trigger}, 32'd1);
        @(posedge clk); #1;
        check_output("redir_latency", {31'd0, redirect_valid}, 32'd1);
        check_output("cause_retained", exception_cause, {28'h0, cause});
    endtask

    // Scoreboard monitor. It samples on the falling edge, away from the
    // active edge. A redirect entry stays at the queue head, and redirect_pc
    // is checked on every cycle of the hold until the handshake completes.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check_output("trigger_exclusive", {31'd0, exception_trigger & mret_trigger}, 32'd0);
            if (exception_trigger) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_trap", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("trap_order", {30'd0, e.kind}, {30'd0, K_TRAP});
                    check_output("trap_cause", exception_cause, e.cause);
                    check_output("trap_pc", exception_pc, e.pc);
                    check_output("trap_value", exception_value, e.value);
                    check_output("trap_flush", {31'd0, flush & stall}, 32'd1);
                end
            end
            if (mret_trigger) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_mret", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("mret_order", {30'd0, e.kind}, {30'd0, K_MRET});
                    check_output("mret_flush", {31'd0, flush & stall}, 32'd1);
                end
            end
            if (redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check_output("redir_order", {30'd0, e.kind}, {30'd0, K_REDIR});
                    check_output("redir_pc", redirect_pc, e.pc);
                    if (redirect_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        rst_n = 1'b0;
        exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0;
        mret_req = 1'b0; irq_pc = 32'h0; commit_ok = 1'b0; ext_irq = 1'b0;
        mstatus_in = 32'h0; mie_in = 32'h0; mip_in = 32'h0;
        mtvec_in = 32'h200; mepc_in = 32'h0; redirect_ready = 1'b1;

        // Reset state
        #3;
        check_output("rst_exc_trigger", {31'd0, exception_trigger}, 32'd0);
        check_output("rst_cause", exception_cause, 32'd0);
        check_output("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check_output("rst_stall_flush", {30'd0, stall, flush}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic exception
        apply_stimulus_exc(4'd2, 32'h100, 32'hDEAD, 32'h200);
        wait_idle("exc_return_idle");

        // Timer interrupt. The CSR file clears MIE once the trap is taken.
        mip_in = 32'h80; mie_in = 32'h80; mstatus_in = 32'h8; commit_ok = 1'b1; irq_pc = 32'h40;
        push_exp(K_TRAP, 32'h8000_0007, 32'h40, 32'h0);
        push_exp(K_REDIR, 32'h0, 32'h200, 32'h0);
        @(posedge clk); #1;
        mstatus_in = 32'h0;
        wait_idle("tmr_return_idle");

        // The timer stays pending but is ineligible with commit_ok=0 and
        // again with MIE=0.
        mstatus_in = 32'h8; commit_ok = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_output("no_irq_commit", {31'd0, stall}, 32'd0);
        mstatus_in = 32'h0; commit_ok = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_output("no_irq_mie", {31'd0, stall}, 32'd0);
        mip_in = 32'h0; mie_in = 32'h0;

        // Priority: exception, MRET and external interrupt arrive together.
        // MRET stays held and must only be taken after the return to IDLE.
        mepc_in = 32'h87;
        mie_in = 32'h800; mstatus_in = 32'h8; ext_irq = 1'b1;
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300; exc_tval = 32'h11;
        mret_req = 1'b1;
        push_exp(K_TRAP, 32'h5, 32'h300, 32'h11);
        push_exp(K_REDIR, 32'h0, 32'h200, 32'h0);
        push_exp(K_MRET, 32'h0, 32'h0, 32'h0);
        push_exp(K_REDIR, 32'h0, 32'h84, 32'h0);
        @(posedge clk); #1;
        exc_valid = 1'b0; mstatus_in = 32'h0; ext_irq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mret_trigger) break;
        end
        mret_req = 1'b0;
        wait_idle("prio_return_idle");
        mie_in = 32'h0;

        // MRET with backpressure: ready stays low for 3 redirect cycles.
        redirect_ready = 1'b0; mepc_in = 32'h84; mret_req = 1'b1;
        push_exp(K_MRET, 32'h0, 32'h0, 32'h0);
        push_exp(K_REDIR, 32'h0, 32'h84, 32'h0);
        @(posedge clk); #1;
        mret_req = 1'b0;
        @(posedge clk); #1;
        mepc_in = 32'h500;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("redir_held", {31'd0, redirect_valid}, 32'd1);
        redirect_ready = 1'b1;
        @(posedge clk); #1;
        check_output("mret_release", {31'd0, stall}, 32'd0);
        mepc_in = 32'h0;

        // External interrupt with mtvec in vectored mode.
        mtvec_in = 32'h301; ext_irq = 1'b1; mie_in = 32'h800; mstatus_in = 32'h8;
        commit_ok = 1'b1; irq_pc = 32'h1234;
        push_exp(K_TRAP, 32'h8000_000B, 32'h1234, 32'h0);
        push_exp(K_REDIR, 32'h0, VEC_EXT_TARGET, 32'h0);
        @(posedge clk); #1;
        mstatus_in = 32'h0; ext_irq = 1'b0;
        wait_idle("vec_return_idle");

        // Exceptions never vector, whatever the mtvec mode.
        apply_stimulus_exc(4'd3, 32'h44, 32'h55, 32'h300);
        wait_idle("vec_exc_return_idle");
        mtvec_in = 32'h200; mie_in = 32'h0;

        // Reset in the middle of a redirect.
        redirect_ready = 1'b0;
        push_exp(K_TRAP, 32'h1, 32'h600, 32'h7);
        push_exp(K_REDIR, 32'h0, 32'h200, 32'h0);
        exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h600; exc_tval = 32'h7;
        @(posedge clk); #1;
        exc_valid = 1'b0;
        @(posedge clk); #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_output("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
        check_output("rst_redir_stall", {31'd0, stall}, 32'd0);
        check_output("rst_redir_pc", redirect_pc, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; redirect_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_output("idle_after_reset", {31'd0, stall}, 32'd0);

        // The DUT still works after the reset.
        apply_stimulus_exc(4'd4, 32'h700, 32'h9, 32'h200);
        wait_idle("final_return_idle");

        repeat (2) @(posedge clk);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_trap_ctrl.md
RV32I_TRAP_CTRL -- requirements
Module: rv32i_trap_ctrl

Interface
REQ-001 SHALL have: clk  input  1  clock, rising-edge; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have: exc_valid  input  1  synchronous exception request from pipeline, level, held until accepted.
REQ-003 SHALL have: exc_cause  input  4  exception code; exc_pc  input  32  faulting PC; exc_tval  input  32  trap value.
REQ-004 SHALL have: mret_req  input  1  MRET request, level, held until accepted.
REQ-005 SHALL have: irq_pc  input  32  PC of next unretired instruction; commit_ok  input  1  pipeline at interruptible boundary.
REQ-006 SHALL have: ext_irq  input  1  machine external interrupt line, level.
REQ-007 SHALL have: mstatus_in, mie_in, mip_in, mtvec_in, mepc_in  input  32 each  current CSR-file values.
REQ-008 SHALL have: exception_trigger  output  1; exception_cause  output  32; exception_pc  output  32; exception_value  output  32  trap-entry command to CSR file.
REQ-009 SHALL have: mret_trigger  output  1  MRET command to CSR file.
REQ-010 SHALL have: redirect_valid  output  1; redirect_pc  output  32; redirect_ready  input  1  fetch redirect handshake.
REQ-011 SHALL have: stall  output  1  hold pipeline; flush  output  1  kill younger instructions, one-cycle pulse.

Function
REQ-012 SHALL implement states IDLE, TRAP, MRET, REDIR; only IDLE samples requests.
REQ-013 In IDLE, SHALL select by priority: exc_valid > mret_req > external interrupt > timer interrupt.
REQ-014 External interrupt SHALL be eligible when ext_irq & mie_in[11] & mstatus_in[3] & commit_ok; timer when mip_in[7] & mie_in[7] & mstatus_in[3] & commit_ok.
REQ-015 On accepting an exception: next state TRAP; latch cause = {28'h0, exc_cause}, pc = exc_pc, value = exc_tval.
REQ-016 On accepting an interrupt: next state TRAP; latch cause = 32'h8000000B (external) or 32'h80000007 (timer), pc = irq_pc, value = 0.
REQ-017 On accepting MRET: next state MRET.
REQ-018 TRAP SHALL last exactly one cycle with exception_trigger=1 and latched cause/pc/value driven; flush=1; latch target from mtvec_in; next REDIR.
REQ-019 MRET SHALL last exactly one cycle with mret_trigger=1, flush=1; latch target = mepc_in; next REDIR.
REQ-020 Latency: request accepted at edge N -> trigger high in cycle N+1 -> redirect_valid high from cycle N+2.
REQ-021 REDIR SHALL hold redirect_valid=1 and redirect_pc stable until redirect_ready=1 sampled; that cycle completes transfer, next IDLE.
REQ-022 redirect_pc SHALL have bits [1:0] forced to 0.
REQ-023 stall SHALL equal 1 in every state except IDLE; exception_trigger and mret_trigger SHALL never be high together.
REQ-024 Requests arriving while not IDLE SHALL be ignored (not queued); requester holds them; re-evaluated on return to IDLE.
REQ-025 exception_cause/pc/value SHALL retain last latched values outside TRAP.
REQ-026 Interrupt eligibility SHALL use mstatus_in as sampled in IDLE; MIE cleared by the CSR file during TRAP prevents re-entry.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE and all outputs 0 (triggers, cause, pc, value, redirect_valid, redirect_pc, stall, flush).
REQ-028 Reset asserted mid-TRAP, MRET or REDIR SHALL abandon the operation; no trigger pulse SHALL occur after reset release until a new request.

Configuration
REQ-029 Macro TRAP_VECTORED_EN: when defined and mtvec_in[1:0]==2'b01 and the trap is an interrupt, target = {mtvec_in[31:2],2'b00} + 4*cause[3:0].
REQ-030 Without TRAP_VECTORED_EN, or for exceptions, target = {mtvec_in[31:2],2'b00} regardless of mtvec_in[1:0].

Verification
REQ-031 exc_valid=1, exc_cause=2, exc_pc=0x100, exc_tval=0xDEAD, mtvec_in=0x200, redirect_ready=1 -> cycle N+1 trigger, cause=0x2, pc=0x100, value=0xDEAD; cycle N+2 redirect_pc=0x200, then IDLE.
REQ-032 mip_in[7]=1, mie_in=0x80, mstatus_in=0x8, commit_ok=1, irq_pc=0x40 -> cause=0x80000007, pc=0x40; commit_ok=0 or mstatus_in[3]=0 -> no trigger.
REQ-033 exc_valid, mret_req, ext_irq all eligible same cycle -> exception taken first; no mret_trigger while not IDLE.
REQ-034 mret_req=1, mepc_in=0x84 -> mret_trigger one cycle; redirect_valid held with pc=0x84 while redirect_ready=0 for 3 cycles, released on 4th.
REQ-035 With TRAP_VECTORED_EN, mtvec_in=0x301, external interrupt -> redirect_pc=0x32C; without macro -> 0x300.
REQ-036 rst_n pulsed low during REDIR -> redirect_valid, stall immediately 0; state IDLE after release.
